// File: rtl/im_program_loader.sv
// im_program_loader: streams 32-bit instruction words into byte-wide instruction memory,
// big-endian from byte 0, holding the mips core in reset until the image is complete.
module im_program_loader #(
  parameter int unsigned IM_BYTES = 1024,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [7:0]        im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W-2:0] word_count
);

  localparam int unsigned    WcW       = ADDR_W - 1;
  localparam logic [WcW-1:0] MaxWords  = WcW'(IM_BYTES / 4);
  localparam logic [3:0]     HoldInit  = 4'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    StIdle, StAccept, StWrite, StHold, StRun, StErrDrain
  } state_t;

  state_t      state_q;
  logic [31:0] shift_q;   // remaining bytes of the latched word, next byte in [31:24]
  logic        last_q;
  logic [1:0]  byte_q;    // index of the byte currently on im_wdata
  logic [3:0]  hold_q;

  // Single FSM; every output is a register updated alongside the state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      last_q       <= 1'b0;
      byte_q       <= '0;
      hold_q       <= '0;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      word_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StRun: begin
          if (load_start) begin
            state_q      <= StAccept;
            in_ready     <= 1'b1;
            cpu_rst      <= 1'b1;
            busy         <= 1'b1;
            word_count   <= '0;
            err_overflow <= 1'b0;
          end
        end
        StAccept: begin
          if (in_valid) begin
            if (word_count == MaxWords) begin
              // Memory full: drop the word and drain the rest of the image.
              err_overflow <= 1'b1;
              if (in_last) begin
                state_q  <= StHold;
                in_ready <= 1'b0;
                hold_q   <= HoldInit;
              end else begin
                state_q  <= StErrDrain;
              end
            end else begin
              state_q  <= StWrite;
              in_ready <= 1'b0;
              im_we    <= 1'b1;
              im_addr  <= ADDR_W'({word_count, 2'b00});
              im_wdata <= in_data[31:24];
              shift_q  <= {in_data[23:0], 8'h00};
              last_q   <= in_last;
              byte_q   <= 2'd0;
            end
          end
        end
        StWrite: begin
          if (byte_q != 2'd3) begin
            byte_q   <= byte_q + 2'd1;
            im_addr  <= im_addr + ADDR_W'(1);
            im_wdata <= shift_q[31:24];
            shift_q  <= {shift_q[23:0], 8'h00};
          end else begin
            im_we      <= 1'b0;
            word_count <= word_count + WcW'(1);
            if (last_q) begin
              state_q <= StHold;
              hold_q  <= HoldInit;
            end else begin
              state_q  <= StAccept;
              in_ready <= 1'b1;
            end
          end
        end
        StErrDrain: begin
          if (in_valid && in_last) begin
            state_q  <= StHold;
            in_ready <= 1'b0;
            hold_q   <= HoldInit;
          end
        end
        StHold: begin
          if (hold_q == 4'd0) begin
            state_q <= StRun;
            cpu_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
